sar_logic: RTL and testbench
============================

# sar_logic

Successive-approximation register controller for the LTspice mixed-signal flow. It sits directly downstream of the comparator and upstream of the capacitive/resistive DAC. It sequences sample, bit-trial and result phases and drives the DAC trial code. It is synthesised onto the ltspice_synth digital cell set (DFFRQ-style flops plus NAND/NOR/XOR gates).

## Interface
- NBITS, 8, conversion resolution; legal range ≥ 2.
- NSAMPLE, 2, number of clock cycles SAMPLE is held high; legal range ≥ 1.

- C  input  1  clock; all state changes on the rising edge.
- R  input  1  reset; asynchronous, active-high. Asserting R immediately forces every output to its reset value.
- START  input  1  conversion request; sampled on rising C edges.
- CMP  input  1  comparator decision: 1 = input ≥ DAC level (keep the trial bit), 0 = clear it.
- SAMPLE  output  1  track/hold switch control. Reset value 0.
- BUSY  output  1  high in SAMPLE and CONVERT states. Reset value 0.
- EOC  output  1  end-of-conversion; one-cycle pulse. Reset value 0.
- D  output  NBITS  DAC trial code. Reset value 0.
- Q  output  NBITS  last completed result. Reset value 0.

## Operation
- FSM states: IDLE, SAMPLE, CONVERT, DONE. The reset state is IDLE.
- IDLE
  - SAMPLE=0, BUSY=0, EOC=0.
  - D holds the last final code (0 after reset), so the DAC does not glitch.
  - START=1 on an edge → SAMPLE.
- SAMPLE
  - SAMPLE=1, BUSY=1.
  - A cycle counter runs NSAMPLE cycles.
  - On the NSAMPLE-th edge → CONVERT, with D = 1<<(NBITS-1) and bit index k = NBITS-1.
- CONVERT
  - BUSY=1, SAMPLE=0.
  - Each bit trial lasts P cycles: P=1 without SAR_CMP_SYNC_EN, P=3 with it.
  - On the deciding edge, D[k] is kept if CMP (or the synchronised CMP) = 1 and cleared otherwise.
  - In the same edge, if k>0, D[k-1] is set and k decrements.
  - Lower bits below the trial bit are always 0.
  - After deciding bit 0 → DONE. In that same edge Q is loaded with the final D.
- DONE
  - EOC=1, BUSY=0, for exactly one cycle.
  - Unconditionally → IDLE. START is ignored in DONE.
- START while BUSY=1 is ignored, with no effect on the conversion in progress.
- START held high continuously gives back-to-back conversions. The period is NSAMPLE + NBITS·P + 2 cycles (DONE + IDLE).
- Reset mid-conversion aborts the conversion.
  - All outputs return to 0 asynchronously. Q is also cleared.
  - After R deasserts, the block waits in IDLE for START.
- Q changes only on entry to DONE. It is stable at all other times.
- The bit counter width is ceil(log2(NBITS)). The sample counter width is ceil(log2(NSAMPLE+1)). Neither counter wraps: both are reloaded at each state entry.

## Timing
- Let e0 be the edge sampling START=1 in IDLE.
  - SAMPLE rises after e0.
  - SAMPLE falls after e(NSAMPLE). D becomes midscale at the same edge.
- Bit NBITS-1-j is decided at edge e(NSAMPLE + (j+1)·P).
- EOC is high during the cycle following edge e(NSAMPLE + NBITS·P). Q is valid from that same edge.
- Latency from the START edge to EOC high is NSAMPLE + NBITS·P cycles.
- D changes only on rising C edges, and stays stable for P cycles per trial. The DAC and comparator must settle within one cycle (P=1) or one cycle before synchronisation (P=3).
- CMP is used only on deciding edges. Without the macro it must meet setup/hold to C.

## Configuration
- SAR_CMP_SYNC_EN
  - Defined: CMP passes through a two-flop synchroniser clocked by C, and the synchroniser flops are reset by R. P=3: one settling cycle plus two synchroniser cycles. The decision uses the synchroniser output on the 3rd edge of each trial. Use this when the comparator is asynchronous to C.
  - Undefined: CMP is sampled directly, P=1, and no synchroniser flops exist.

## Test plan
NBITS=8 and NSAMPLE=2 unless stated.
- Ideal comparator CMP=(D ≤ 0xA5), one START pulse → SAMPLE high for 2 cycles. D sequence is 80,C0,A0,B0,A8,A4,A6,A5. EOC pulses after edge e10. Q=0xA5 and BUSY=0 in the EOC cycle.
- CMP stuck at 0 → Q=0x00. CMP stuck at 1 → Q=0xFF. In both cases EOC fires exactly once per START, after 10 edges.
- START pulsed again at e4, while BUSY → ignored: a single EOC at e10, and Q is unchanged from the clean run.
- R asserted asynchronously at mid-cycle during bit 3 → D, Q, SAMPLE, BUSY and EOC all read 0 before the next edge. A new START after R deasserts gives a correct full conversion.
- START held high for 30 cycles, with CMP=(D ≤ 0x3C) → EOC every 12 cycles. Q=0x3C each time, and D holds 0x3C during IDLE.
- SAR_CMP_SYNC_EN defined, CMP=(D ≤ 0x5A) → each D value is held for 3 cycles. EOC fires after edge e26. Q=0x5A.

Source files
------------

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller between the comparator and the DAC.
// Latency: NSAMPLE + NBITS*P cycles from the START edge to EOC high (P=1, or P=3 with sync).
// Backpressure: none; START is ignored while BUSY and while in DONE.
//
// Ports:
//   C       clock, all state changes on the rising edge
//   R       asynchronous active-high reset; forces every output to 0 at once
//   START   conversion request, sampled in IDLE
//   CMP     comparator decision (1 = keep trial bit)
//   SAMPLE  track/hold switch, high for NSAMPLE cycles
//   BUSY    high during SAMPLE and CONVERT
//   EOC     one-cycle end-of-conversion pulse
//   D       DAC trial code; holds the last final code while idle
//   Q       last completed result, updated only on entry to DONE
//
// Build option: define SAR_CMP_SYNC_EN to pass CMP through a two-flop
// synchroniser; each bit trial then takes 3 cycles instead of 1.

module sar_logic #(
  parameter int NBITS   = 8,
  parameter int NSAMPLE = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic             START,
  input  logic             CMP,
  output logic             SAMPLE,
  output logic             BUSY,
  output logic             EOC,
  output logic [NBITS-1:0] D,
  output logic [NBITS-1:0] Q
);

  // Bit index only has to reach NBITS-1; sample counter only NSAMPLE-1,
  // but is sized for NSAMPLE so NSAMPLE=1 still gets a one-bit counter.
  localparam int KW = $clog2(NBITS);
  localparam int SW = $clog2(NSAMPLE + 1);

  localparam logic [KW-1:0]    K_MSB    = KW'(NBITS - 1);
  localparam logic [SW-1:0]    S_LAST   = SW'(NSAMPLE - 1);
  localparam logic [NBITS-1:0] MIDSCALE = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    scnt_q,  scnt_d;
  logic [KW-1:0]    k_q,     k_d;
  logic [NBITS-1:0] dac_q,   dac_d;
  logic [NBITS-1:0] res_q,   res_d;

  // Decision source and "this edge decides the current bit" strobe.
  logic cmp_use;
  logic trial_end;

`ifdef SAR_CMP_SYNC_EN
  // Two-flop synchroniser for an asynchronous comparator, plus a phase
  // counter so each trial spans one settling cycle and two sync cycles.
  // The decision on the third edge uses CMP captured on the first edge
  // after D changed, which is the value produced by the settled DAC.
  logic       cmp_s1_q, cmp_s1_d;
  logic       cmp_s2_q, cmp_s2_d;
  logic [1:0] ph_q,     ph_d;

  always_comb begin
    cmp_s1_d = CMP;
    cmp_s2_d = cmp_s1_q;
  end

  // Phase sits at 0 outside CONVERT, so it is fresh on CONVERT entry,
  // and it restarts after every decision.
  always_comb begin
    ph_d = ph_q;
    if ((state_q != ST_CONVERT) || trial_end) begin
      ph_d = 2'd0;
    end else begin
      ph_d = ph_q + 2'd1;
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
      ph_q     <= 2'd0;
    end else begin
      cmp_s1_q <= cmp_s1_d;
      cmp_s2_q <= cmp_s2_d;
      ph_q     <= ph_d;
    end
  end

  assign cmp_use   = cmp_s2_q;
  assign trial_end = (ph_q == 2'd2);
`else
  // Comparator is synchronous to C: every CONVERT edge decides a bit.
  assign cmp_use   = CMP;
  assign trial_end = 1'b1;
`endif

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    k_d     = k_q;
    dac_d   = dac_q;
    res_d   = res_q;

    unique case (state_q)
      ST_IDLE: begin
        // D keeps the last final code so the DAC does not glitch.
        if (START) begin
          state_d = ST_SAMPLE;
          scnt_d  = '0;
        end
      end

      ST_SAMPLE: begin
        if (scnt_q == S_LAST) begin
          state_d = ST_CONVERT;
          dac_d   = MIDSCALE;
          k_d     = K_MSB;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      ST_CONVERT: begin
        if (trial_end) begin
          // Resolve the trial bit, then either raise the next one or finish.
          // Bits below the trial bit are never set, so they stay 0.
          dac_d[k_q] = cmp_use;
          if (k_q != '0) begin
            dac_d[k_q - 1'b1] = 1'b1;
            k_d               = k_q - 1'b1;
          end else begin
            state_d = ST_DONE;
            res_d   = dac_d;
          end
        end
      end

      ST_DONE: begin
        // START deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      k_q     <= '0;
      dac_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      k_q     <= k_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
    end
  end

  // Status outputs decode straight from the state flop, so reset clears
  // them as soon as R rises.
  assign SAMPLE = (state_q == ST_SAMPLE);
  assign BUSY   = (state_q == ST_SAMPLE) || (state_q == ST_CONVERT);
  assign EOC    = (state_q == ST_DONE);
  assign D      = dac_q;
  assign Q      = res_q;

endmodule

// File: tb/tb_sar_logic.sv
// tb_sar_logic: randomized self-checking bench for sar_logic.
// Reference: comparator modelled as a function of D, result by binary search.
// Outputs sampled on the falling edge; inputs driven there too.

module tb_sar_logic;

  localparam int NB = 8;
  localparam int NS = 2;
`ifdef SAR_CMP_SYNC_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif
  localparam int LAT = NS + NB * P;

  logic          C;
  logic          R;
  logic          START;
  logic          CMP;
  logic          SAMPLE;
  logic          BUSY;
  logic          EOC;
  logic [NB-1:0] D;
  logic [NB-1:0] Q;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mode     = 0;
  logic [NB-1:0] thr      = '0;
  logic [NB-1:0] prev_d   = '0;
  logic [NB-1:0] prev_q   = '0;
  logic [NB-1:0] d_seq [NB];

  sar_logic #(.NBITS(NB), .NSAMPLE(NS)) dut (
    .C      (C),
    .R      (R),
    .START  (START),
    .CMP    (CMP),
    .SAMPLE (SAMPLE),
    .BUSY   (BUSY),
    .EOC    (EOC),
    .D      (D),
    .Q      (Q)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Comparator behaviour: 0 ideal (D <= thr), 1 stuck-0, 2 stuck-1,
  // 3 arbitrary non-monotonic decision (parity of D & thr).
  function automatic logic cmp_fn(input int m, input logic [NB-1:0] t,
                                  input logic [NB-1:0] x);
    case (m)
      0:       return (x <= t);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ^(x & t);
    endcase
  endfunction

  always_comb CMP = cmp_fn(mode, thr, D);

  // Code presented to the DAC during trial j (bit NB-1-j under test).
  function automatic logic [NB-1:0] model_trial(input int m, input logic [NB-1:0] t,
                                                input int j);
    logic [NB-1:0] code;
    logic [NB-1:0] one;
    logic [NB-1:0] trial;
    code = '0;
    one  = 1;
    for (int i = 0; i < j; i++) begin
      trial = code | (one << (NB - 1 - i));
      if (cmp_fn(m, t, trial)) code = trial;
    end
    return code | (one << (NB - 1 - j));
  endfunction

  function automatic logic [NB-1:0] model_result(input int m, input logic [NB-1:0] t);
    logic [NB-1:0] last;
    last = model_trial(m, t, NB - 1);
    return cmp_fn(m, t, last) ? last : (last & ~logic'(1'b1));
  endfunction

  // One conversion from an idle negedge; checks every cycle up to two past EOC.
  // restart_at > 0 re-pulses START so it is sampled at edge e(restart_at).
  task automatic run_conv(input int m, input logic [NB-1:0] t, input int restart_at,
                          input string nm);
    logic [NB-1:0]     res;
    logic [NB-1:0]     dexp;
    logic [NB-1:0]     qexp;
    logic [2:0]        fexp;
    logic [2+2*NB:0]   ev;
    logic [2+2*NB:0]   av;
    res   = model_result(m, t);
    mode  = m;
    thr   = t;
    START = 1'b1;
    @(negedge C);
    for (int n = 0; n <= LAT + 2; n++) begin
      START = (n == restart_at - 1);
      if (n < NS) begin
        fexp = 3'b110; dexp = prev_d; qexp = prev_q;
      end else if (n < LAT) begin
        fexp = 3'b010; dexp = model_trial(m, t, (n - NS) / P); qexp = prev_q;
        if (((n - NS) % P) == 0) d_seq[(n - NS) / P] = D;
      end else if (n == LAT) begin
        fexp = 3'b001; dexp = res; qexp = res;
      end else begin
        fexp = 3'b000; dexp = res; qexp = res;
      end
      ev = {fexp, dexp, qexp};
      av = {SAMPLE, BUSY, EOC, D, Q};
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL %s e%0d: got SBE=%b D=%h Q=%h, want SBE=%b D=%h Q=%h",
                 nm, n, av[2+2*NB:2*NB], D, Q, fexp, dexp, qexp);
      end
      if (n < LAT + 2) @(negedge C);
    end
    START  = 1'b0;
    prev_d = res;
    prev_q = res;
  endtask

  task automatic test_reset;
    R = 1'b0; START = 1'b0;
    #1 R = 1'b1;
    #1;
    n_checks++;
    if ({SAMPLE, BUSY, EOC, D, Q} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got SBE=%b%b%b D=%h Q=%h, want all 0", SAMPLE, BUSY, EOC, D, Q);
    end
    @(negedge C);
    START = 1'b1;  // must be ignored while R is high
    @(negedge C);
    n_checks++;
    if ({SAMPLE, BUSY, EOC, D, Q} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got SBE=%b%b%b D=%h Q=%h, want all 0", SAMPLE, BUSY, EOC, D, Q);
    end
    START = 1'b0;
    R     = 1'b0;
    @(negedge C);
  endtask

  task automatic test_ideal;
    logic [NB-1:0] tbl [NB];
    tbl = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    run_conv(0, 8'hA5, 0, "ideal");
    for (int j = 0; j < NB; j++) begin
      n_checks++;
      if (d_seq[j] !== tbl[j]) begin
        n_fail++;
        $display("FAIL ideal_dseq[%0d]: got %h, want %h", j, d_seq[j], tbl[j]);
      end
    end
    n_checks++;
    if (Q !== 8'hA5) begin
      n_fail++;
      $display("FAIL ideal_q: got %h, want a5", Q);
    end
  endtask

  task automatic test_stuck;
    run_conv(1, 8'($urandom), 0, "stuck0");
    n_checks++;
    if (Q !== 8'h00) begin
      n_fail++;
      $display("FAIL stuck0_q: got %h, want 00", Q);
    end
    run_conv(2, 8'($urandom), 0, "stuck1");
    n_checks++;
    if (Q !== 8'hFF) begin
      n_fail++;
      $display("FAIL stuck1_q: got %h, want ff", Q);
    end
  endtask

  task automatic test_start_while_busy;
    run_conv(0, 8'hA5, 4, "busy_start");
    n_checks++;
    if (Q !== 8'hA5) begin
      n_fail++;
      $display("FAIL busy_start_q: got %h, want a5", Q);
    end
  endtask

  task automatic test_async_reset;
    logic [NB-1:0] t;
    t     = 8'($urandom);
    mode  = 0;
    thr   = t;
    START = 1'b1;
    @(negedge C);
    START = 1'b0;
    repeat (NS + 4 * P) @(negedge C);  // inside the bit-3 trial
    n_checks++;
    if ({BUSY, D} !== {1'b1, model_trial(0, t, 4)}) begin
      n_fail++;
      $display("FAIL rst_pre: got BUSY=%b D=%h, want BUSY=1 D=%h", BUSY, D, model_trial(0, t, 4));
    end
    #1 R = 1'b1;
    #1;
    n_checks++;
    if ({SAMPLE, BUSY, EOC, D, Q} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got SBE=%b%b%b D=%h Q=%h, want all 0", SAMPLE, BUSY, EOC, D, Q);
    end
    @(negedge C);
    R = 1'b0;
    repeat (3) @(negedge C);
    n_checks++;
    if ({SAMPLE, BUSY, EOC, D, Q} !== '0) begin
      n_fail++;
      $display("FAIL rst_idle: got SBE=%b%b%b D=%h Q=%h, want all 0", SAMPLE, BUSY, EOC, D, Q);
    end
    prev_d = '0;
    prev_q = '0;
    run_conv(0, 8'($urandom), 0, "post_reset");
  endtask

  task automatic test_back_to_back;
    int            per;
    int            nstart;
    int            last;
    int            k;
    int            o;
    int            eoc_cnt;
    logic [NB-1:0] res;
    logic [NB-1:0] dexp;
    logic [NB-1:0] qexp;
    logic [2:0]    fexp;
    per     = LAT + 2;
    nstart  = (30 + per - 1) / per;
    last    = nstart * per + 1;
    eoc_cnt = 0;
    mode    = 0;
    thr     = 8'h3C;
    res     = model_result(0, 8'h3C);
    START   = 1'b1;
    @(negedge C);
    for (int n = 0; n <= last; n++) begin
      START = (n < 29);
      k = n / per;
      o = n % per;
      if (k >= nstart || o > LAT) begin
        fexp = 3'b000; dexp = res; qexp = res;
      end else if (o < NS) begin
        fexp = 3'b110; dexp = (k == 0) ? prev_d : res; qexp = (k == 0) ? prev_q : res;
      end else if (o < LAT) begin
        fexp = 3'b010; dexp = model_trial(0, 8'h3C, (o - NS) / P);
        qexp = (k == 0) ? prev_q : res;
      end else begin
        fexp = 3'b001; dexp = res; qexp = res;
      end
      if (EOC === 1'b1) eoc_cnt++;
      n_checks++;
      if ({SAMPLE, BUSY, EOC, D, Q} !== {fexp, dexp, qexp}) begin
        n_fail++;
        $display("FAIL b2b e%0d: got SBE=%b%b%b D=%h Q=%h, want SBE=%b D=%h Q=%h",
                 n, SAMPLE, BUSY, EOC, D, Q, fexp, dexp, qexp);
      end
      if (n < last) @(negedge C);
    end
    START = 1'b0;
    n_checks++;
    if (eoc_cnt != nstart) begin
      n_fail++;
      $display("FAIL b2b_eoc_count: got %0d, want %0d", eoc_cnt, nstart);
    end
    n_checks++;
    if (Q !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_q: got %h, want 3c", Q);
    end
    prev_d = res;
    prev_q = res;
    @(negedge C);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_conv(int'($urandom_range(0, 3)), 8'($urandom),
               int'($urandom_range(0, LAT + 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
